// File: rtl/pc_unit_irq.sv
// Fetch program counter with four jump modes plus a prioritised, vectored, nesting interrupt controller.
// Latency: one cycle from retiring inputs to pc_new. No backpressure: every retire and take completes in its cycle.
module pc_unit_irq #(
    parameter int XLEN         = 16,
    parameter int IRQ_CHANNELS = 4,
    parameter int STACK_DEPTH  = 4,
    parameter int RESET_VECTOR = 0,
    parameter int ILEN         = 4,
    parameter int VEC_STRIDE   = 4,
    localparam int LW          = $clog2(IRQ_CHANNELS + 1)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    pcflag,
    input  logic [1:0]              jump,
    input  logic [XLEN-1:0]         imm,
    input  logic [IRQ_CHANNELS-1:0] irq_req,
    input  logic                    irq_en,
    input  logic [XLEN-1:0]         vec_base,
    output logic [XLEN-1:0]         pc_new,
    output logic                    pc_misaligned,
    output logic [IRQ_CHANNELS-1:0] irq_ack,
    output logic                    irq_active,
    output logic [LW-1:0]           irq_level,
    output logic                    stack_full,
    output logic                    mret_underflow
);

    localparam int SPW = $clog2(STACK_DEPTH + 1);

    logic [XLEN-1:0]         pc_q, pc_d;
    logic [LW-1:0]           level_q, level_d;
    logic [SPW-1:0]          sp_q, sp_d;
    logic [XLEN-1:0]         ret_q [STACK_DEPTH];
    logic [XLEN-1:0]         ret_d [STACK_DEPTH];
    logic [LW-1:0]           lvl_q [STACK_DEPTH];
    logic [LW-1:0]           lvl_d [STACK_DEPTH];
    logic [IRQ_CHANNELS-1:0] irq_ack_q, irq_ack_d;
    logic                    mret_underflow_q, mret_underflow_d;

    logic [XLEN-1:0] next_seq;
    logic [XLEN-1:0] top_ret;
    logic [LW-1:0]   top_lvl;
    logic [LW-1:0]   win;
    logic            found;
    logic            mret;
    logic            full;
    logic            empty;
    logic            take;

    always_comb begin
        next_seq = pc_q;
        if (pcflag) begin
            case (jump)
                2'b00:   next_seq = pc_q + imm;
                2'b01:   next_seq = imm;
                default: next_seq = pc_q + XLEN'(ILEN);
            endcase
        end
        mret = pcflag && (jump == 2'b11);

        // Scan downwards so the lowest requesting index is left as the winner.
        found = 1'b0;
        win   = '0;
        for (int i = IRQ_CHANNELS - 1; i >= 0; i--) begin
            if (irq_req[i]) begin
                found = 1'b1;
                win   = LW'(i);
            end
        end

        full  = (sp_q == SPW'(STACK_DEPTH));
        empty = (sp_q == '0);
        take  = irq_en && found && (win < level_q) && !full && !mret;

        top_ret = pc_q;
        top_lvl = level_q;
        for (int i = 0; i < STACK_DEPTH; i++) begin
            if (sp_q == SPW'(i + 1)) begin
                top_ret = ret_q[i];
                top_lvl = lvl_q[i];
            end
        end

        pc_d             = next_seq;
        level_d          = level_q;
        sp_d             = sp_q;
        ret_d            = ret_q;
        lvl_d            = lvl_q;
        irq_ack_d        = '0;
        mret_underflow_d = 1'b0;

        // MRET beats a same-cycle interrupt; the request is re-judged against the restored level.
        if (mret) begin
            if (!empty) begin
                pc_d    = top_ret;
                level_d = top_lvl;
                sp_d    = sp_q - SPW'(1);
            end else begin
                pc_d             = pc_q + XLEN'(ILEN);
                mret_underflow_d = 1'b1;
            end
        end else if (take) begin
            pc_d      = vec_base + XLEN'(win) * XLEN'(VEC_STRIDE);
            level_d   = win;
            sp_d      = sp_q + SPW'(1);
            irq_ack_d = IRQ_CHANNELS'(1) << win;
            for (int i = 0; i < STACK_DEPTH; i++) begin
                if (sp_q == SPW'(i)) begin
                    ret_d[i] = next_seq;
                    lvl_d[i] = level_q;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            pc_q             <= XLEN'(RESET_VECTOR);
            level_q          <= LW'(IRQ_CHANNELS);
            sp_q             <= '0;
            irq_ack_q        <= '0;
            mret_underflow_q <= 1'b0;
            for (int i = 0; i < STACK_DEPTH; i++) begin
                ret_q[i] <= '0;
                lvl_q[i] <= '0;
            end
        end else begin
            pc_q             <= pc_d;
            level_q          <= level_d;
            sp_q             <= sp_d;
            irq_ack_q        <= irq_ack_d;
            mret_underflow_q <= mret_underflow_d;
            for (int i = 0; i < STACK_DEPTH; i++) begin
                ret_q[i] <= ret_d[i];
                lvl_q[i] <= lvl_d[i];
            end
        end
    end

    assign pc_new         = pc_q;
    assign pc_misaligned  = |pc_q[1:0];
    assign irq_ack        = irq_ack_q;
    assign irq_active     = (sp_q != '0);
    assign irq_level      = level_q;
    assign stack_full     = (sp_q == SPW'(STACK_DEPTH));
    assign mret_underflow = mret_underflow_q;

endmodule

// File: tb/tb_pc_unit_irq.sv
// Directed bench for pc_unit_irq: jump modes, wrap, nesting, pending, stack full, underflow, reset mid-ISR.
module tb_pc_unit_irq;

    logic        clk;
    logic        reset;
    logic        pcflag;
    logic [1:0]  jump;
    logic [15:0] imm;
    logic [3:0]  irq_req;
    logic        irq_en;
    logic [15:0] vec_base;
    logic [15:0] pc_new;
    logic        pc_misaligned;
    logic [3:0]  irq_ack;
    logic        irq_active;
    logic [2:0]  irq_level;
    logic        stack_full;
    logic        mret_underflow;

    int checks = 0;
    int passed = 0;

    pc_unit_irq dut (
        .clk            (clk),
        .reset          (reset),
        .pcflag         (pcflag),
        .jump           (jump),
        .imm            (imm),
        .irq_req        (irq_req),
        .irq_en         (irq_en),
        .vec_base       (vec_base),
        .pc_new         (pc_new),
        .pc_misaligned  (pc_misaligned),
        .irq_ack        (irq_ack),
        .irq_active     (irq_active),
        .irq_level      (irq_level),
        .stack_full     (stack_full),
        .mret_underflow (mret_underflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0; pcflag = 1'b1; jump = 2'b10;
        tick(); tick();
        checks++; if (pc_new !== 16'h0000) $display("FAIL rst_pc got %h want 0000", pc_new); else passed++;
        checks++; if (irq_level !== 3'd4) $display("FAIL rst_level got %0d want 4", irq_level); else passed++;
        checks++; if (irq_active !== 1'b0) $display("FAIL rst_active got %b want 0", irq_active); else passed++;
        checks++; if (irq_ack !== 4'b0000) $display("FAIL rst_ack got %b want 0000", irq_ack); else passed++;
        checks++; if (mret_underflow !== 1'b0) $display("FAIL rst_uf got %b want 0", mret_underflow); else passed++;
        reset = 1'b1;
        tick(); tick(); tick();
        checks++; if (pc_new !== 16'h000C) $display("FAIL inc3 got %h want 000C", pc_new); else passed++;
        pcflag = 1'b0;
    endtask

    task automatic test_jumps();
        pcflag = 1'b1; jump = 2'b01; imm = 16'h0010; tick();
        jump = 2'b00; imm = 16'hFFF8; tick();
        checks++; if (pc_new !== 16'h0008) $display("FAIL rel_neg got %h want 0008", pc_new); else passed++;
        jump = 2'b01; imm = 16'h0102; tick();
        checks++; if (pc_new !== 16'h0102) $display("FAIL abs got %h want 0102", pc_new); else passed++;
        checks++; if (pc_misaligned !== 1'b1) $display("FAIL misalign got %b want 1", pc_misaligned); else passed++;
        imm = 16'hFFFE; tick();
        jump = 2'b10; tick();
        checks++; if (pc_new !== 16'h0002) $display("FAIL inc_wrap got %h want 0002", pc_new); else passed++;
        pcflag = 1'b0; jump = 2'b00; imm = 16'h0050; tick();
        checks++; if (pc_new !== 16'h0002) $display("FAIL hold got %h want 0002", pc_new); else passed++;
    endtask

    task automatic test_nesting();
        pcflag = 1'b1; jump = 2'b01; imm = 16'h0020; tick();
        jump = 2'b10; irq_req = 4'b0100; tick();
        checks++; if (irq_ack !== 4'b0100) $display("FAIL n_ack2 got %b want 0100", irq_ack); else passed++;
        checks++; if (pc_new !== 16'h0108) $display("FAIL n_vec2 got %h want 0108", pc_new); else passed++;
        checks++; if (irq_level !== 3'd2 || irq_active !== 1'b1) $display("FAIL n_lvl2 got %0d/%b want 2/1", irq_level, irq_active); else passed++;
        pcflag = 1'b0; tick();
        checks++; if (irq_ack !== 4'b0000 || pc_new !== 16'h0108) $display("FAIL n_pulse got %b/%h want 0000/0108", irq_ack, pc_new); else passed++;
        irq_req = 4'b0001; tick();
        checks++; if (irq_ack !== 4'b0001 || pc_new !== 16'h0100 || irq_level !== 3'd0) $display("FAIL n_pre0 got %b/%h/%0d want 0001/0100/0", irq_ack, pc_new, irq_level); else passed++;
        irq_req = 4'b0000; pcflag = 1'b1; jump = 2'b11; tick();
        checks++; if (pc_new !== 16'h0108 || irq_level !== 3'd2) $display("FAIL n_mret1 got %h/%0d want 0108/2", pc_new, irq_level); else passed++;
        tick();
        checks++; if (pc_new !== 16'h0024 || irq_level !== 3'd4 || irq_active !== 1'b0) $display("FAIL n_mret2 got %h/%0d/%b want 0024/4/0", pc_new, irq_level, irq_active); else passed++;
        pcflag = 1'b0;
    endtask

    task automatic test_pending();
        irq_req = 4'b0010; tick();
        checks++; if (pc_new !== 16'h0104 || irq_level !== 3'd1) $display("FAIL p_take1 got %h/%0d want 0104/1", pc_new, irq_level); else passed++;
        irq_req = 4'b0100; tick();
        checks++; if (irq_ack !== 4'b0000 || pc_new !== 16'h0104) $display("FAIL p_lower got %b/%h want 0000/0104", irq_ack, pc_new); else passed++;
        irq_req = 4'b0001; pcflag = 1'b1; jump = 2'b11; tick();
        checks++; if (irq_ack !== 4'b0000 || pc_new !== 16'h0024 || irq_level !== 3'd4) $display("FAIL p_mret_wins got %b/%h/%0d want 0000/0024/4", irq_ack, pc_new, irq_level); else passed++;
        pcflag = 1'b0; tick();
        checks++; if (irq_ack !== 4'b0001 || pc_new !== 16'h0100) $display("FAIL p_retake got %b/%h want 0001/0100", irq_ack, pc_new); else passed++;
        irq_req = 4'b0000; pcflag = 1'b1; jump = 2'b11; tick();
        checks++; if (pc_new !== 16'h0024 || irq_level !== 3'd4) $display("FAIL p_back got %h/%0d want 0024/4", pc_new, irq_level); else passed++;
        pcflag = 1'b0;
    endtask

    task automatic test_stack_full();
        logic [15:0] exp_pc;
        for (int ch = 3; ch >= 0; ch--) begin
            irq_req = 4'b0001 << ch; tick();
            exp_pc = 16'h0100 + 16'(ch * 4);
            checks++; if (pc_new !== exp_pc) $display("FAIL f_fill%0d got %h want %h", ch, pc_new, exp_pc); else passed++;
        end
        checks++; if (stack_full !== 1'b1 || irq_level !== 3'd0) $display("FAIL f_full got %b/%0d want 1/0", stack_full, irq_level); else passed++;
        irq_req = 4'b1111; tick();
        checks++; if (irq_ack !== 4'b0000 || pc_new !== 16'h0100) $display("FAIL f_held got %b/%h want 0000/0100", irq_ack, pc_new); else passed++;
        irq_req = 4'b0001; pcflag = 1'b1; jump = 2'b11; tick();
        checks++; if (pc_new !== 16'h0104 || irq_level !== 3'd1 || stack_full !== 1'b0) $display("FAIL f_pop got %h/%0d/%b want 0104/1/0", pc_new, irq_level, stack_full); else passed++;
        pcflag = 1'b0; tick();
        checks++; if (irq_ack !== 4'b0001 || stack_full !== 1'b1) $display("FAIL f_refill got %b/%b want 0001/1", irq_ack, stack_full); else passed++;
        irq_req = 4'b0000; pcflag = 1'b1; jump = 2'b11;
        tick(); tick(); tick(); tick();
        checks++; if (pc_new !== 16'h0024 || irq_level !== 3'd4 || irq_active !== 1'b0) $display("FAIL f_unwind got %h/%0d/%b want 0024/4/0", pc_new, irq_level, irq_active); else passed++;
        jump = 2'b01; imm = 16'h0040; tick();
        jump = 2'b11; tick();
        checks++; if (pc_new !== 16'h0044 || mret_underflow !== 1'b1 || irq_level !== 3'd4) $display("FAIL f_uf got %h/%b/%0d want 0044/1/4", pc_new, mret_underflow, irq_level); else passed++;
        pcflag = 1'b0; tick();
        checks++; if (mret_underflow !== 1'b0 || pc_new !== 16'h0044) $display("FAIL f_uf_pulse got %b/%h want 0/0044", mret_underflow, pc_new); else passed++;
    endtask

    task automatic test_reset_mid();
        for (int ch = 3; ch >= 1; ch--) begin
            irq_req = 4'b0001 << ch; tick();
        end
        checks++; if (irq_level !== 3'd1 || irq_active !== 1'b1) $display("FAIL r_nest got %0d/%b want 1/1", irq_level, irq_active); else passed++;
        irq_req = 4'b0010; reset = 1'b0; tick();
        checks++; if (pc_new !== 16'h0000 || irq_level !== 3'd4 || irq_active !== 1'b0 || irq_ack !== 4'b0000) $display("FAIL r_mid got %h/%0d/%b/%b want 0000/4/0/0000", pc_new, irq_level, irq_active, irq_ack); else passed++;
        reset = 1'b1; tick();
        checks++; if (irq_ack !== 4'b0010 || pc_new !== 16'h0104) $display("FAIL r_retake got %b/%h want 0010/0104", irq_ack, pc_new); else passed++;
        reset = 1'b0; tick();
        reset = 1'b1; irq_en = 1'b0; irq_req = 4'b0001; tick();
        checks++; if (irq_ack !== 4'b0000 || pc_new !== 16'h0000) $display("FAIL r_en_off got %b/%h want 0000/0000", irq_ack, pc_new); else passed++;
        irq_en = 1'b1; tick();
        checks++; if (irq_ack !== 4'b0001 || pc_new !== 16'h0100) $display("FAIL r_en_on got %b/%h want 0001/0100", irq_ack, pc_new); else passed++;
    endtask

    initial begin
        reset = 1'b0; pcflag = 1'b0; jump = 2'b00; imm = 16'h0000;
        irq_req = 4'b0000; irq_en = 1'b1; vec_base = 16'h0100;
        test_reset();
        test_jumps();
        test_nesting();
        test_pending();
        test_stack_full();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
